mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory stage that consumes the execute stage's result (ALU result, op code, store data, load/store controls).
- Word loads/stores run over a req/ack data-memory bus; non-memory results pass through unchanged.
- Produces one registered writeback beat per accepted instruction and stalls the front of the pipe through in_ready while a bus transfer is outstanding.

Parameters:
- TIMEOUT, 16: max cycles mem_req stays high without mem_ack before abort; legal range 2..255.
- ADDR_W, 32: width of mem_addr and of the ALU result port.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous and active-low.
- in_valid  in  1  EX result valid this cycle.
- in_ready  out  1  unit can accept; high only in IDLE.
- ALUop_i  in  5  op code from EX; carried to wb_op.
- ALUOut  in  ADDR_W  ALU result; used as byte address for memory ops.
- DataOutReg2  in  32  store data.
- MemRead  in  1  instruction is a word load.
- MemWrite  in  1  instruction is a word store.
- rd_i  in  5  destination register.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  word-aligned byte address.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  load data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- wb_valid  out  1  one-cycle writeback beat.
- wb_we  out  1  register-file write enable.
- wb_rd  out  5  destination register.
- wb_data  out  32  writeback value.
- wb_op  out  5  op code of the retiring instruction.
- err  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal (MemRead and MemWrite both set); valid with wb_valid.

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE; all outputs 0 except in_ready = 1.
  - Timeout counter cleared.
  - mem_req falls immediately, with no clock edge required.
- FSM states: IDLE, REQ, RESP.
- Accept = in_valid && in_ready. On accept, latch ALUOut, DataOutReg2, rd_i, ALUop_i, MemRead and MemWrite.
- IDLE, accept of a non-memory op (MemRead = MemWrite = 0):
  - Next cycle: wb_valid = 1, wb_data = ALUOut, wb_we = (rd_i != 0), err = 00.
  - State stays IDLE, so latency is 1 and throughput is 1 per cycle.
- IDLE, accept with MemRead && MemWrite:
  - No bus activity.
  - Next cycle: wb_valid = 1, wb_we = 0, wb_data = 0, err = 11.
- IDLE, accept of a memory op with ALUOut[1:0] != 0:
  - No bus activity.
  - Next cycle: wb_valid = 1, wb_we = 0, wb_data = ALUOut, err = 01.
- IDLE, accept of an aligned memory op:
  - Go to REQ.
  - From the next cycle: mem_req = 1, mem_addr = latched ALUOut, mem_we = MemWrite, mem_wdata = latched data (0 for loads).
- REQ, bus hold:
  - mem_req, mem_addr, mem_we and mem_wdata stay stable until ack or abort.
  - Counter increments each REQ cycle without ack.
- REQ, mem_ack sampled high:
  - Drop mem_req and go to RESP.
  - Load: capture mem_rdata.
- RESP (one cycle):
  - Assert wb_valid and return to IDLE.
  - Load: wb_data = captured rdata, wb_we = (rd != 0).
  - Store: wb_we = 0, wb_data = 0.
  - err = 00.
- Latency: if ack arrives in the n-th REQ cycle, wb_valid rises n+1 cycles after the accept edge.
- Timeout: on the TIMEOUT-th consecutive REQ cycle without ack:
  - Drop mem_req and go to RESP with wb_we = 0, err = 10.
  - An ack in that same cycle wins, i.e. normal completion.
- mem_ack outside REQ is ignored, including a late ack after an abort or after reset.
- in_ready is combinational from state, so in_ready = 1 in the RESP-to-IDLE return cycle. Back-to-back accept is legal in the cycle wb_valid is high.
- Downstream never back-pressures; wb_valid is a pulse.
- Reset mid-transfer abandons the transaction with no writeback beat.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, REQ, RESP}.
  - err codes ERR_NONE / ERR_MISALIGN / ERR_TIMEOUT / ERR_ILLEGAL.
  - op-code constants OP_LW = 5'b10100, OP_SW = 5'b10101.
- One sub-module, mem_timeout_ctr:
  - clear/enable inputs and an expired output.
  - Width $clog2(TIMEOUT+1).

Test Plan:
- Non-memory op: ALUOut = 0x0000_002A, rd_i = 5, MemRead = MemWrite = 0 -> next cycle wb_valid = 1, wb_data = 0x2A, wb_we = 1, err = 00, in_ready stays 1.
- Load: ALUOut = 0x100, MemRead = 1, rd_i = 3, ack on the 3rd REQ cycle with rdata = 0xDEADBEEF:
  - mem_req high 3 cycles with mem_addr = 0x100, mem_we = 0.
  - wb_valid 4 cycles after accept with wb_data = 0xDEADBEEF, wb_we = 1.
- Store: ALUOut = 0x204, DataOutReg2 = 0x12345678, MemWrite = 1, ack after 1 cycle -> mem_we = 1, mem_wdata = 0x12345678; wb_valid = 1 with wb_we = 0, err = 00.
- Misaligned load: ALUOut = 0x102 -> mem_req never rises; wb_valid next cycle with err = 01, wb_we = 0.
- Timeout: TIMEOUT = 4, load with no ack:
  - mem_req high exactly 4 cycles, then wb_valid with err = 10.
  - An ack injected 2 cycles later causes no output.
- Reset mid-REQ: drop rst during the 2nd REQ cycle -> mem_req low before the next clock edge, no wb_valid; after release, in_ready = 1 and a new load completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access stage.
package mem_pkg;

    // Control states of the memory stage.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Error code that travels with every writeback beat.
    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } err_t;

    // Op codes of the word load and word store instructions.
    localparam logic [4:0] OP_LW = 5'b10100;
    localparam logic [4:0] OP_SW = 5'b10101;

    // A word access is legal only when the byte address has zero low bits.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts consecutive un-acknowledged request cycles and flags the last one.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Counter holds the number of request cycles already spent without ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // The cycle that sees TIMEOUT-1 earlier misses is the TIMEOUT-th one.
    assign o_expired = (r_count == LAST_CNT);

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: passes ALU results through and runs word loads/stores
// over a req/ack bus, producing one registered writeback beat each.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        ALUop_i,
    input  logic [ADDR_W-1:0] ALUOut,
    input  logic [31:0]       DataOutReg2,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [4:0]        rd_i,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_op,
    output logic [1:0]        err
);

    state_t      r_state;
    logic [4:0]  r_rd;
    logic [4:0]  r_op;
    logic        r_is_store;
    logic        r_timed_out;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_clear;
    logic        w_count;
    logic        w_expired;

    assign in_ready = (r_state == IDLE);
    assign w_accept = in_valid && in_ready;

    // The counter only runs while a request is pending and unanswered.
    assign w_clear  = (r_state != REQ);
    assign w_count  = (r_state == REQ) && !mem_ack;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_enable  (w_count),
        .o_expired (w_expired)
    );

    // Control FSM with all bus and writeback outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_rd        <= '0;
            r_op        <= '0;
            r_is_store  <= 1'b0;
            r_timed_out <= 1'b0;
            r_rdata     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            wb_op       <= '0;
            err         <= ERR_NONE;
        end else begin
            // Writeback is a single-cycle pulse; idle values are zero.
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_op    <= '0;
            err      <= ERR_NONE;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rd       <= rd_i;
                        r_op       <= ALUop_i;
                        r_is_store <= MemWrite;
                        if (MemRead && MemWrite) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_i;
                            wb_op    <= ALUop_i;
                            err      <= ERR_ILLEGAL;
                        end else if (!MemRead && !MemWrite) begin
                            wb_valid <= 1'b1;
                            wb_we    <= (rd_i != 5'd0);
                            wb_rd    <= rd_i;
                            wb_data  <= 32'(ALUOut);
                            wb_op    <= ALUop_i;
                        end else if (!is_word_aligned(ALUOut[1:0])) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_i;
                            wb_data  <= 32'(ALUOut);
                            wb_op    <= ALUop_i;
                            err      <= ERR_MISALIGN;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= MemWrite;
                            mem_addr  <= ALUOut;
                            mem_wdata <= MemWrite ? DataOutReg2 : 32'd0;
                            r_state   <= REQ;
                        end
                    end
                end

                REQ: begin
                    // An ack in the expiry cycle still completes normally.
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        mem_we      <= 1'b0;
                        mem_addr    <= '0;
                        mem_wdata   <= '0;
                        r_rdata     <= r_is_store ? 32'd0 : mem_rdata;
                        r_timed_out <= 1'b0;
                        r_state     <= RESP;
                    end else if (w_expired) begin
                        mem_req     <= 1'b0;
                        mem_we      <= 1'b0;
                        mem_addr    <= '0;
                        mem_wdata   <= '0;
                        r_rdata     <= '0;
                        r_timed_out <= 1'b1;
                        r_state     <= RESP;
                    end
                end

                RESP: begin
                    wb_valid <= 1'b1;
                    wb_rd    <= r_rd;
                    wb_op    <= r_op;
                    if (r_timed_out) begin
                        err <= ERR_TIMEOUT;
                    end else begin
                        wb_data <= r_rdata;
                        wb_we   <= !r_is_store && (r_rd != 5'd0);
                    end
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT = 4).
module tb_mem_access_unit;

    localparam int TIMEOUT = 4;
    localparam int ADDR_W  = 32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  ALUop_i;
    logic [31:0] ALUOut;
    logic [31:0] DataOutReg2;
    logic        MemRead;
    logic        MemWrite;
    logic [4:0]  rd_i;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  wb_op;
    logic [1:0]  err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_unit #(
        .TIMEOUT (TIMEOUT),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ALUop_i     (ALUop_i),
        .ALUOut      (ALUOut),
        .DataOutReg2 (DataOutReg2),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .rd_i        (rd_i),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .wb_valid    (wb_valid),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_op       (wb_op),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input logic rd_en, input logic wr_en, input logic [4:0] rd);
        in_valid    = 1'b1;
        ALUop_i     = op;
        ALUOut      = addr;
        DataOutReg2 = data;
        MemRead     = rd_en;
        MemWrite    = wr_en;
        rd_i        = rd;
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        ALUop_i     = '0;
        ALUOut      = '0;
        DataOutReg2 = '0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        rd_i        = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        rst       = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        idle_inputs();
        #3;
        check_value("rst_in_ready", 32'(in_ready), 32'd1);
        check_value("rst_mem_req",  32'(mem_req),  32'd0);
        check_value("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_value("rst_err",      32'(err),      32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Non-memory pass-through.
        drive_op(5'd1, 32'h0000_002A, 32'd0, 1'b0, 1'b0, 5'd5);
        tick();
        idle_inputs();
        check_value("alu_wb_valid", 32'(wb_valid), 32'd1);
        check_value("alu_wb_data",  wb_data,       32'h2A);
        check_value("alu_wb_we",    32'(wb_we),    32'd1);
        check_value("alu_wb_rd",    32'(wb_rd),    32'd5);
        check_value("alu_wb_op",    32'(wb_op),    32'd1);
        check_value("alu_err",      32'(err),      32'd0);
        check_value("alu_in_ready", 32'(in_ready), 32'd1);
        tick();
        check_value("alu_pulse",    32'(wb_valid), 32'd0);

        // Load, ack in the 3rd request cycle.
        drive_op(5'b10100, 32'h100, 32'd0, 1'b1, 1'b0, 5'd3);
        tick();
        idle_inputs();
        for (int k = 1; k <= 3; k++) begin
            check_value($sformatf("ld_req_c%0d", k),  32'(mem_req),  32'd1);
            check_value($sformatf("ld_addr_c%0d", k), mem_addr,      32'h100);
            check_value($sformatf("ld_we_c%0d", k),   32'(mem_we),   32'd0);
            check_value($sformatf("ld_rdy_c%0d", k),  32'(in_ready), 32'd0);
            if (k == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
            tick();
            mem_ack   = 1'b0;
            mem_rdata = '0;
        end
        check_value("ld_req_drop",  32'(mem_req),  32'd0);
        check_value("ld_wb_early",  32'(wb_valid), 32'd0);
        // Back-to-back op presented while the load retires.
        tick();
        check_value("ld_wb_valid",  32'(wb_valid), 32'd1);
        check_value("ld_wb_data",   wb_data,       32'hDEAD_BEEF);
        check_value("ld_wb_we",     32'(wb_we),    32'd1);
        check_value("ld_wb_rd",     32'(wb_rd),    32'd3);
        check_value("ld_wb_op",     32'(wb_op),    32'h14);
        check_value("ld_err",       32'(err),      32'd0);
        check_value("ld_in_ready",  32'(in_ready), 32'd1);
        drive_op(5'd2, 32'h7, 32'd0, 1'b0, 1'b0, 5'd0);
        tick();
        idle_inputs();
        check_value("b2b_wb_valid", 32'(wb_valid), 32'd1);
        check_value("b2b_wb_data",  wb_data,       32'h7);
        check_value("b2b_wb_we_r0", 32'(wb_we),    32'd0);

        // Store, ack in the 1st request cycle.
        drive_op(5'b10101, 32'h204, 32'h1234_5678, 1'b0, 1'b1, 5'd9);
        tick();
        idle_inputs();
        check_value("st_req",       32'(mem_req), 32'd1);
        check_value("st_we",        32'(mem_we),  32'd1);
        check_value("st_addr",      mem_addr,     32'h204);
        check_value("st_wdata",     mem_wdata,    32'h1234_5678);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_value("st_req_drop",  32'(mem_req),  32'd0);
        tick();
        check_value("st_wb_valid",  32'(wb_valid), 32'd1);
        check_value("st_wb_we",     32'(wb_we),    32'd0);
        check_value("st_wb_data",   wb_data,       32'd0);
        check_value("st_err",       32'(err),      32'd0);

        // Misaligned load.
        drive_op(5'b10100, 32'h102, 32'd0, 1'b1, 1'b0, 5'd4);
        tick();
        idle_inputs();
        check_value("mis_req",      32'(mem_req),  32'd0);
        check_value("mis_wb_valid", 32'(wb_valid), 32'd1);
        check_value("mis_err",      32'(err),      32'd1);
        check_value("mis_wb_we",    32'(wb_we),    32'd0);
        check_value("mis_wb_data",  wb_data,       32'h102);
        tick();
        check_value("mis_req_after", 32'(mem_req), 32'd0);

        // Both MemRead and MemWrite set.
        drive_op(5'd3, 32'h200, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd6);
        tick();
        idle_inputs();
        check_value("ill_req",      32'(mem_req),  32'd0);
        check_value("ill_wb_valid", 32'(wb_valid), 32'd1);
        check_value("ill_err",      32'(err),      32'd3);
        check_value("ill_wb_we",    32'(wb_we),    32'd0);
        check_value("ill_wb_data",  wb_data,       32'd0);

        // Load with no ack: aborts after TIMEOUT request cycles.
        drive_op(5'b10100, 32'h300, 32'd0, 1'b1, 1'b0, 5'd6);
        tick();
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            check_value($sformatf("to_req_c%0d", k), 32'(mem_req), 32'd1);
            tick();
        end
        check_value("to_req_drop",  32'(mem_req),  32'd0);
        check_value("to_wb_early",  32'(wb_valid), 32'd0);
        tick();
        check_value("to_wb_valid",  32'(wb_valid), 32'd1);
        check_value("to_err",       32'(err),      32'd2);
        check_value("to_wb_we",     32'(wb_we),    32'd0);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        beats = 0;
        for (int k = 0; k < 4; k++) begin
            if (wb_valid || mem_req) beats++;
            tick();
        end
        check_value("late_ack_quiet", 32'(beats), 32'd0);

        // Reset during the 2nd request cycle.
        drive_op(5'b10100, 32'h400, 32'd0, 1'b1, 1'b0, 5'd7);
        tick();
        idle_inputs();
        tick();
        check_value("rr_req_c2",    32'(mem_req),  32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_value("rr_req_async", 32'(mem_req),  32'd0);
        check_value("rr_in_ready",  32'(in_ready), 32'd1);
        tick();
        rst = 1'b1;
        beats = 0;
        for (int k = 0; k < 3; k++) begin
            if (wb_valid) beats++;
            tick();
        end
        check_value("rr_no_wb",     32'(beats),    32'd0);
        check_value("rr_ready",     32'(in_ready), 32'd1);
        drive_op(5'b10100, 32'h500, 32'd0, 1'b1, 1'b0, 5'd8);
        tick();
        idle_inputs();
        check_value("rr_new_req",   32'(mem_req),  32'd1);
        check_value("rr_new_addr",  mem_addr,      32'h500);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        tick();
        check_value("rr_wb_valid",  32'(wb_valid), 32'd1);
        check_value("rr_wb_data",   wb_data,       32'hCAFE_F00D);
        check_value("rr_wb_rd",     32'(wb_rd),    32'd8);
        check_value("rr_wb_we",     32'(wb_we),    32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
